// File: rtl/quantum_scheduler_pkg.sv
// Shared definitions for the quantum scheduler: FSM encoding, trap causes and
// the OS entry address used on every trap.
package quantum_scheduler_pkg;

    localparam logic [2:0] ST_OS     = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_TRAP   = 3'd4;

    localparam logic [1:0] TRAP_NONE  = 2'b00;
    localparam logic [1:0] TRAP_QTM   = 2'b01;
    localparam logic [1:0] TRAP_HALT  = 2'b10;
    localparam logic [1:0] TRAP_EMPTY = 2'b11;

    localparam logic [31:0] OS_BASE = 32'd0;

    // A zero quantum would never expire, so it is promoted to one instruction.
    function automatic logic [31:0] quantum_norm(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/quantum_scheduler_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start_i,
// wrapping modulo N (N must be a power of two).
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] cand;

    // Scan from the farthest offset back to start_i so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        cand    = start_i;
        for (int i = N - 1; i >= 0; i--) begin
            cand = start_i + W'(i);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin process scheduler driving the PC load port: dispatches ready
// processes, counts retired user instructions and traps to the OS on expiry/halt.
module quantum_scheduler
    import quantum_scheduler_pkg::*;
#(
    parameter int          NPROC  = 4,
    parameter logic [31:0] OS_END = 32'd687,
    parameter logic [31:0] QDEF   = 32'd16,
    parameter int          SW     = $clog2(NPROC)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          retire,
    input  logic [31:0]   next_pc,
    input  logic          halt,
    input  logic          q_we,
    input  logic [31:0]   q_val,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_slot,
    input  logic [31:0]   cfg_pc,
    input  logic          dispatch,
    output logic          pc_load,
    output logic [31:0]   pc_target,
    output logic          running,
    output logic [SW-1:0] cur_slot,
    output logic [1:0]    trap_cause,
    output logic          all_done,
    output logic [2:0]    state_dbg
);

    logic [2:0]       state_q, state_d;
    logic [NPROC-1:0] ready_q, ready_d;
    logic [31:0]      pc_q [NPROC];
    logic [31:0]      pc_d [NPROC];
    logic [SW-1:0]    cur_q, cur_d;
    logic [31:0]      q_pend_q, q_pend_d;
    logic [31:0]      q_act_q, q_act_d;
    logic [31:0]      qcnt_q, qcnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             done_q;

    logic [SW-1:0]    scan_start;
    logic             pick_found;
    logic [SW-1:0]    pick_idx;

    assign scan_start = cur_q + SW'(1);

    rr_pick #(.N(NPROC), .W(SW)) u_pick (
        .req_i   (ready_q),
        .start_i (scan_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        pc_d     = pc_q;
        cur_d    = cur_q;
        q_pend_d = q_pend_q;
        q_act_d  = q_act_q;
        qcnt_d   = qcnt_q;
        cause_d  = cause_q;

        if (q_we) q_pend_d = quantum_norm(q_val);

        // The running slot's entry belongs to the live process and is protected.
        if (cfg_we && !(state_q == ST_RUN && cfg_slot == cur_q)) begin
            ready_d[cfg_slot] = 1'b1;
            pc_d[cfg_slot]    = cfg_pc;
        end

        case (state_q)
            ST_OS: if (dispatch) state_d = ST_SELECT;
            ST_SELECT: begin
                if (pick_found) begin
                    cur_d   = pick_idx;
                    cause_d = TRAP_NONE;
                    state_d = ST_LOAD;
                end else begin
                    cause_d = TRAP_EMPTY;
                    state_d = ST_OS;
                end
            end
            ST_LOAD: begin
                qcnt_d  = 32'd0;
                q_act_d = q_pend_q;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (retire) begin
                    if (halt) begin
                        ready_d[cur_q] = 1'b0;
                        cause_d        = TRAP_HALT;
                        state_d        = ST_TRAP;
                    end else if (next_pc >= OS_END) begin
                        // Retires heading below OS_END are syscalls and not charged.
                        if (qcnt_q == q_act_q - 32'd1) begin
                            pc_d[cur_q] = next_pc;
                            cause_d     = TRAP_QTM;
                            state_d     = ST_TRAP;
                        end else begin
                            qcnt_d = qcnt_q + 32'd1;
                        end
                    end
                end
            end
            ST_TRAP: state_d = ST_OS;
            default: state_d = ST_OS;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_OS;
            ready_q  <= '0;
            for (int i = 0; i < NPROC; i++) pc_q[i] <= 32'd0;
            cur_q    <= SW'(NPROC - 1);
            q_pend_q <= quantum_norm(QDEF);
            q_act_q  <= quantum_norm(QDEF);
            qcnt_q   <= 32'd0;
            cause_q  <= TRAP_NONE;
            done_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            pc_q     <= pc_d;
            cur_q    <= cur_d;
            q_pend_q <= q_pend_d;
            q_act_q  <= q_act_d;
            qcnt_q   <= qcnt_d;
            cause_q  <= cause_d;
            done_q   <= ~|ready_d;
        end
    end

    assign pc_load    = (state_q == ST_LOAD) || (state_q == ST_TRAP);
    assign pc_target  = (state_q == ST_LOAD) ? pc_q[cur_q] : OS_BASE;
    assign running    = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign cur_slot   = cur_q;
    assign trap_cause = cause_q;
    assign all_done   = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Self-checking bench for quantum_scheduler: directed scenarios followed by
// randomized dispatch/retire traffic compared against a transaction-level model.
module tb_quantum_scheduler;

    localparam int NPROC  = 4;
    localparam int SW     = 2;
    localparam int OS_END = 687;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          retire = 1'b0;
    logic [31:0]   next_pc = '0;
    logic          halt = 1'b0;
    logic          q_we = 1'b0;
    logic [31:0]   q_val = '0;
    logic          cfg_we = 1'b0;
    logic [SW-1:0] cfg_slot = '0;
    logic [31:0]   cfg_pc = '0;
    logic          dispatch = 1'b0;
    logic          pc_load;
    logic [31:0]   pc_target;
    logic          running;
    logic [SW-1:0] cur_slot;
    logic [1:0]    trap_cause;
    logic          all_done;
    logic [2:0]    state_dbg;

    quantum_scheduler #(.NPROC(NPROC), .OS_END(32'd687), .QDEF(32'd16)) dut (
        .clock(clock), .reset(reset), .retire(retire), .next_pc(next_pc),
        .halt(halt), .q_we(q_we), .q_val(q_val), .cfg_we(cfg_we),
        .cfg_slot(cfg_slot), .cfg_pc(cfg_pc), .dispatch(dispatch),
        .pc_load(pc_load), .pc_target(pc_target), .running(running),
        .cur_slot(cur_slot), .trap_cause(trap_cause), .all_done(all_done),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Behavioural model: process table plus scheduling bookkeeping.
    logic [NPROC-1:0] m_ready;
    logic [31:0]      m_pc [NPROC];
    int               m_cur;
    int unsigned      m_qpend, m_qact, m_cnt;
    logic [1:0]       m_cause;
    bit               m_run;
    logic [31:0]      exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input bit e_load, input logic [31:0] e_tgt, input bit e_run);
        if (e_load) exp_q.push_back(e_tgt);
        chk("pc_load", {31'd0, pc_load}, {31'd0, e_load});
        if (pc_load === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
            else chk("pc_target", pc_target, exp_q.pop_front());
        end
        exp_q.delete();
        chk("running", {31'd0, running}, {31'd0, e_run});
        chk("cur_slot", {30'd0, cur_slot}, 32'(m_cur));
        chk("trap_cause", {30'd0, trap_cause}, {30'd0, m_cause});
        chk("all_done", {31'd0, all_done}, {31'd0, (m_ready == '0)});
    endtask

    task automatic model_reset();
        m_ready = '0;
        for (int i = 0; i < NPROC; i++) m_pc[i] = 32'd0;
        m_cur   = NPROC - 1;
        m_qpend = 16;
        m_qact  = 16;
        m_cnt   = 0;
        m_cause = 2'b00;
        m_run   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        retire = 1'b0; halt = 1'b0; q_we = 1'b0; cfg_we = 1'b0; dispatch = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        check_outputs(1'b0, 32'd0, 1'b0);
    endtask

    task automatic cfg_write(input int slot, input logic [31:0] pc);
        cfg_we = 1'b1; cfg_slot = SW'(slot); cfg_pc = pc;
        tick();
        cfg_we = 1'b0;
        if (!(m_run && slot == m_cur)) begin
            m_ready[slot] = 1'b1;
            m_pc[slot]    = pc;
        end
        check_outputs(1'b0, 32'd0, m_run);
    endtask

    task automatic set_quantum(input logic [31:0] v);
        q_we = 1'b1; q_val = v;
        tick();
        q_we = 1'b0;
        m_qpend = (v == 0) ? 1 : v;
        check_outputs(1'b0, 32'd0, m_run);
    endtask

    // Dispatch from the OS; optionally write a table entry in the SELECT cycle.
    task automatic dispatch_op(input bit sel_cfg, input int s_slot, input logic [31:0] s_pc);
        int pick;
        dispatch = 1'b1;
        tick();
        dispatch = 1'b0;
        check_outputs(1'b0, 32'd0, 1'b0);
        pick = -1;
        for (int k = 1; k <= NPROC; k++)
            if (pick < 0 && m_ready[(m_cur + k) % NPROC]) pick = (m_cur + k) % NPROC;
        if (sel_cfg) begin
            cfg_we = 1'b1; cfg_slot = SW'(s_slot); cfg_pc = s_pc;
        end
        tick();
        cfg_we = 1'b0;
        if (sel_cfg) begin
            m_ready[s_slot] = 1'b1;
            m_pc[s_slot]    = s_pc;
        end
        if (pick >= 0) begin
            m_cur   = pick;
            m_cause = 2'b00;
            check_outputs(1'b1, m_pc[m_cur], 1'b1);
            m_qact = m_qpend;
            m_cnt  = 0;
            m_run  = 1'b1;
            tick();
            check_outputs(1'b0, 32'd0, 1'b1);
        end else begin
            m_cause = 2'b11;
            check_outputs(1'b0, 32'd0, 1'b0);
        end
    endtask

    task automatic retire_op(input logic [31:0] npc, input bit h);
        bit trap;
        retire = 1'b1; next_pc = npc; halt = h;
        trap = 1'b0;
        if (h) begin
            m_ready[m_cur] = 1'b0;
            m_cause = 2'b10;
            trap = 1'b1;
        end else if (npc >= OS_END) begin
            m_cnt++;
            if (m_cnt == m_qact) begin
                m_pc[m_cur] = npc;
                m_cause = 2'b01;
                trap = 1'b1;
            end
        end
        tick();
        retire = 1'b0; halt = 1'b0;
        if (trap) begin
            m_run = 1'b0;
            check_outputs(1'b1, 32'd0, 1'b0);
            tick();
            check_outputs(1'b0, 32'd0, 1'b0);
        end else begin
            check_outputs(1'b0, 32'd0, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Basic dispatch and quantum expiry.
        cfg_write(0, 32'd700);
        cfg_write(2, 32'd900);
        set_quantum(32'd3);
        dispatch_op(1'b0, 0, 32'd0);
        retire_op(32'd701, 1'b0);
        retire_op(32'd702, 1'b0);
        retire_op(32'd703, 1'b0);
        dispatch_op(1'b0, 0, 32'd0);
        // Halt on the quantum's last instruction outranks expiry.
        retire_op(32'd901, 1'b0);
        retire_op(32'd902, 1'b0);
        retire_op(32'd903, 1'b1);
        dispatch_op(1'b0, 0, 32'd0);
        retire_op(32'd704, 1'b1);
        dispatch_op(1'b0, 0, 32'd0);

        // Syscall retires are free; a mid-run quantum write waits for the next dispatch.
        cfg_write(1, 32'd800);
        dispatch_op(1'b0, 0, 32'd0);
        repeat (5) retire_op(32'd100, 1'b0);
        set_quantum(32'd5);
        cfg_write(1, 32'd1234);
        retire_op(32'd801, 1'b0);
        retire_op(32'd802, 1'b0);
        retire_op(32'd803, 1'b0);
        dispatch_op(1'b0, 0, 32'd0);
        for (int i = 0; i < 5; i++) retire_op(32'(804 + i), 1'b0);

        // Reset while running, then an empty dispatch.
        dispatch_op(1'b0, 0, 32'd0);
        retire_op(32'd900, 1'b0);
        do_reset();
        dispatch_op(1'b0, 0, 32'd0);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            int ncfg;
            int nret;
            if ($urandom_range(0, 40) == 0) do_reset();
            ncfg = $urandom_range(0, 2);
            for (int c = 0; c < ncfg; c++)
                cfg_write($urandom_range(0, NPROC - 1), 32'($urandom_range(OS_END, 5000)));
            if ($urandom_range(0, 3) == 0) set_quantum(32'($urandom_range(0, 6)));
            if (m_ready != '0 && $urandom_range(0, 4) == 0)
                dispatch_op(1'b1, $urandom_range(0, NPROC - 1), 32'($urandom_range(OS_END, 5000)));
            else
                dispatch_op(1'b0, 0, 32'd0);
            nret = 0;
            while (m_run && nret < 20) begin
                case ($urandom_range(0, 9))
                    0: set_quantum(32'($urandom_range(0, 6)));
                    1: cfg_write($urandom_range(0, NPROC - 1), 32'($urandom_range(OS_END, 5000)));
                    2: retire_op(32'($urandom_range(1, OS_END - 1)), 1'b0);
                    3: retire_op(32'($urandom_range(OS_END, 5000)), ($urandom_range(0, 1) == 1));
                    default: retire_op(32'($urandom_range(OS_END, 5000)), 1'b0);
                endcase
                nret++;
            end
            if (m_run) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
